// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter for an 8 x 11-bit register bank: IDLE -> GRANT -> COMMIT.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise A has fixed priority.
module regfile_write_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [2:0]  addr_a,
  input  logic [10:0] data_a,
  input  logic        req_b,
  input  logic [2:0]  addr_b,
  input  logic [10:0] data_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [7:0]  chosen,
  output logic        w_en,
  output logic [10:0] w_data,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, GRANT, COMMIT} state_t;

  state_t      state;
  logic [2:0]  addr_q;
  logic [10:0] data_q;
  logic        win_b;
  logic        pick_b;
  logic        winner_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_b;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    pick_b = req_b;
    if (req_a && req_b) pick_b = ~last_b;
  end
`else
  always_comb begin
    pick_b = req_b & ~req_a;
  end
`endif

  assign winner_req = win_b ? req_b : req_a;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      win_b  <= 1'b0;
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      chosen <= '0;
      w_en   <= 1'b0;
      w_data <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_b <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            state  <= GRANT;
            win_b  <= pick_b;
            addr_q <= pick_b ? addr_b : addr_a;
            data_q <= pick_b ? data_b : data_a;
            gnt_a  <= ~pick_b;
            gnt_b  <= pick_b;
            busy   <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_b <= pick_b;
`endif
          end
        end
        GRANT: begin
          state  <= COMMIT;
          gnt_a  <= 1'b0;
          gnt_b  <= 1'b0;
          w_en   <= 1'b1;
          chosen <= 8'd1 << addr_q;
          w_data <= data_q;
        end
        COMMIT: begin
          state  <= IDLE;
          w_en   <= 1'b0;
          chosen <= '0;
          w_data <= '0;
          busy   <= 1'b0;
          // The winner must have released its request by the end of COMMIT.
          if (winner_req) err <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          gnt_a  <= 1'b0;
          gnt_b  <= 1'b0;
          w_en   <= 1'b0;
          chosen <= '0;
          w_data <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: vector table, corner sequences, random run vs model.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [2:0]  addr_a = '0, addr_b = '0;
  logic [10:0] data_a = '0, data_b = '0;
  logic        gnt_a, gnt_b, w_en, busy, err;
  logic [7:0]  chosen;
  logic [10:0] w_data;

  int checks = 0;
  int failures = 0;

  logic [10:0] bank [8] = '{default: 11'h000};

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .chosen(chosen), .w_en(w_en),
    .w_data(w_data), .busy(busy), .err(err)
  );

  // Register bank fed by the arbiter's write port.
  always @(posedge clk) begin
    if (w_en)
      for (int i = 0; i < 8; i++)
        if (chosen[i]) bank[i] <= w_data;
  end

  typedef struct {
    logic        ra;
    logic [2:0]  aa;
    logic [10:0] da;
    logic        rb;
    logic [2:0]  ab;
    logic [10:0] db;
    int          win_fixed;
    int          win_rr;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pack(input logic ga, input logic gb, input logic [7:0] ch,
                                       input logic we, input logic [10:0] wd,
                                       input logic bs, input logic er);
    return {ga, gb, ch, we, wd, bs, er};
  endfunction

  function automatic logic [23:0] outs();
    return {gnt_a, gnt_b, chosen, w_en, w_data, busy, err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic int tie_pick(input int fixed_w, input int rr_w);
`ifdef ARB_ROUND_ROBIN_EN
    return rr_w;
`else
    return fixed_w;
`endif
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [19:0] ewr;
    int g_t[$];
    int g_id[$];
    int cnt_a, cnt_b;
    int seen_gb, bad_wr, a_wr;
    int p_t[$];
    logic [10:0] p_d[$];

    // ---------------- vector table ----------------
    vt[0] = '{1'b1, 3'd3, 11'h5A5, 1'b0, 3'd0, 11'h000, 1, 1};
    vt[1] = '{1'b0, 3'd0, 11'h000, 1'b1, 3'd0, 11'h123, 2, 2};
    vt[2] = '{1'b1, 3'd1, 11'h0F0, 1'b1, 3'd2, 11'h70F, 1, 1};
    vt[3] = '{1'b1, 3'd4, 11'h111, 1'b1, 3'd5, 11'h222, 1, 2};
    vt[4] = '{1'b0, 3'd6, 11'h333, 1'b0, 3'd7, 11'h444, 0, 0};
    vt[5] = '{1'b0, 3'd0, 11'h000, 1'b1, 3'd7, 11'h7FF, 2, 2};
    vt[6] = '{1'b1, 3'd7, 11'h001, 1'b1, 3'd6, 11'h555, 1, 1};
    vt[7] = '{1'b1, 3'd5, 11'h2AA, 1'b0, 3'd0, 11'h000, 1, 1};
    vt[8] = '{1'b1, 3'd0, 11'h3C3, 1'b1, 3'd1, 11'h4B4, 1, 2};

    do_reset();
    #1;
    chk("reset_state", 32'(outs()), 32'(pack(0, 0, 8'h00, 0, 11'h000, 0, 0)));

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      req_a = vt[i].ra; addr_a = vt[i].aa; data_a = vt[i].da;
      req_b = vt[i].rb; addr_b = vt[i].ab; data_b = vt[i].db;
      tick();
      w = tie_pick(vt[i].win_fixed, vt[i].win_rr);
      chk($sformatf("vec%0d_grant", i), {28'd0, gnt_a, gnt_b, busy, w_en},
          {28'd0, (w == 1), (w == 2), (w != 0), 1'b0});
      req_a = 1'b0; req_b = 1'b0;
      tick();
      ewr = '0;
      if (w == 1) ewr = {1'b1, 8'd1 << vt[i].aa, vt[i].da};
      if (w == 2) ewr = {1'b1, 8'd1 << vt[i].ab, vt[i].db};
      chk($sformatf("vec%0d_write", i), 32'({w_en, chosen, w_data}), 32'(ewr));
      tick();
      chk($sformatf("vec%0d_idle", i), {28'd0, busy, w_en, gnt_a | gnt_b, err}, 32'd0);
      chk($sformatf("vec%0d_chosen_idle", i), 32'(chosen), 32'd0);
    end

    // ---------------- continuous requests from both ----------------
    do_reset();
    @(negedge clk);
    req_a = 1'b1; addr_a = 3'd1; data_a = 11'h011;
    req_b = 1'b1; addr_b = 3'd2; data_b = 11'h022;
    cnt_a = 0; cnt_b = 0;
    for (int t = 0; t < 13; t++) begin
      tick();
      if (gnt_a) begin g_t.push_back(t); g_id.push_back(1); end
      if (gnt_b) begin g_t.push_back(t); g_id.push_back(2); end
      if (gnt_a) begin req_a = 1'b0; cnt_a = 2; end
      else if (cnt_a > 0) begin cnt_a--; if (cnt_a == 0) req_a = 1'b1; end
      if (gnt_b) begin req_b = 1'b0; cnt_b = 2; end
      else if (cnt_b > 0) begin cnt_b--; if (cnt_b == 0) req_b = 1'b1; end
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("cont_grant_count", g_t.size(), 5);
    for (int k = 0; k < g_t.size() && k < 5; k++) begin
      chk($sformatf("cont_grant%0d_time", k), g_t[k], 3 * k);
`ifdef ARB_ROUND_ROBIN_EN
      chk($sformatf("cont_grant%0d_id", k), g_id[k], (k % 2 == 0) ? 1 : 2);
`else
      chk($sformatf("cont_grant%0d_id", k), g_id[k], 1);
`endif
    end
    chk("cont_err", 32'(err), 32'd0);
    tick(); tick(); tick();

    // ---------------- withdrawn request ----------------
    do_reset();
    @(negedge clk);
    req_a = 1'b1; addr_a = 3'd2; data_a = 11'h0AA;
    seen_gb = 0; bad_wr = 0; a_wr = 0;
    for (int t = 0; t < 7; t++) begin
      tick();
      if (gnt_b) seen_gb++;
      if (w_en && chosen[6]) bad_wr++;
      if (w_en && chosen[2]) a_wr++;
      if (t == 0) begin req_a = 1'b0; req_b = 1'b1; addr_b = 3'd6; data_b = 11'h666; end
      if (t == 1) req_b = 1'b0;
    end
    chk("withdraw_gnt_b", seen_gb, 0);
    chk("withdraw_write_b", bad_wr, 0);
    chk("withdraw_write_a", a_wr, 1);
    chk("withdraw_err", 32'(err), 32'd0);

    // ---------------- protocol error is sticky ----------------
    do_reset();
    @(negedge clk);
    req_a = 1'b1; addr_a = 3'd4; data_a = 11'h044;
    tick();
    chk("err_gnt", 32'(gnt_a), 32'd1);
    tick();
    chk("err_before", 32'(err), 32'd0);
    tick();
    chk("err_set", 32'(err), 32'd1);
    req_a = 1'b0;
    for (int t = 0; t < 13; t++) tick();
    chk("err_sticky", {30'd0, err, busy}, 32'd2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("err_cleared", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- reset during COMMIT ----------------
    do_reset();
    @(negedge clk);
    req_a = 1'b1; addr_a = 3'd5; data_a = 11'h155;
    tick(); req_a = 1'b0;
    tick(); tick();
    @(negedge clk);
    req_b = 1'b1; addr_b = 3'd5; data_b = 11'h2AA;
    tick();
    chk("abort_gnt_b", 32'(gnt_b), 32'd1);
    req_b = 1'b0;
    tick();
    chk("abort_commit", 32'({w_en, chosen}), 32'({1'b1, 8'h20}));
    #2 rst = 1'b0;
    #1;
    chk("abort_outputs", 32'({w_en, chosen, busy, w_data}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_bank5", 32'(bank[5]), 32'h155);
    rst = 1'b1;

    // ---------------- same address, serialized ----------------
    do_reset();
    @(negedge clk);
    req_a = 1'b1; addr_a = 3'd7; data_a = 11'h001;
    req_b = 1'b1; addr_b = 3'd7; data_b = 11'h7FF;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (w_en) begin p_t.push_back(t); p_d.push_back(w_data); end
      if (gnt_a) req_a = 1'b0;
      if (gnt_b) req_b = 1'b0;
    end
    chk("same_pulses", p_t.size(), 2);
    if (p_t.size() == 2) begin
      chk("same_spacing", p_t[1] - p_t[0], 3);
      chk("same_first", 32'(p_d[0]), 32'h001);
      chk("same_final", 32'(p_d[1]), 32'h7FF);
    end
    chk("same_bank7", 32'(bank[7]), 32'h7FF);

    // ---------------- random traffic vs schedule model ----------------
    begin
      int free_edge, acc_edge;
      logic acc_b, last_b_m, mb;
      logic [2:0] acc_addr;
      logic [10:0] acc_data;
      logic [10:0] bank_m [8];
      logic written [8];
      int cool_a, cool_b;
      logic eg, ew;
      for (int i = 0; i < 8; i++) begin bank_m[i] = '0; written[i] = 1'b0; end
      free_edge = 0; acc_edge = -10; acc_b = 1'b0; last_b_m = 1'b1;
      acc_addr = '0; acc_data = '0; cool_a = 0; cool_b = 0;
      do_reset();
      for (int e = 0; e < 600; e++) begin
        if (e >= free_edge && (req_a || req_b)) begin
          mb = req_b;
`ifdef ARB_ROUND_ROBIN_EN
          if (req_a && req_b) mb = ~last_b_m;
`else
          if (req_a && req_b) mb = 1'b0;
`endif
          acc_b = mb; last_b_m = mb;
          acc_edge = e; free_edge = e + 3;
          acc_addr = mb ? addr_b : addr_a;
          acc_data = mb ? data_b : data_a;
          bank_m[acc_addr] = acc_data;
          written[acc_addr] = 1'b1;
        end
        tick();
        eg = (acc_edge == e);
        ew = (acc_edge == e - 1);
        chk($sformatf("rand_e%0d", e), 32'(outs()),
            32'(pack(eg & ~acc_b, eg & acc_b, ew ? (8'd1 << acc_addr) : 8'h00,
                     ew, ew ? acc_data : 11'h000, eg | ew, 1'b0)));
        if (gnt_a) begin req_a = 1'b0; cool_a = 2; end
        else if (req_a) begin if ($urandom_range(7) == 0) req_a = 1'b0; end
        else if (cool_a > 0) cool_a--;
        else if ($urandom_range(2) == 0) begin
          req_a = 1'b1; addr_a = 3'($urandom_range(7)); data_a = 11'($urandom);
        end
        if (gnt_b) begin req_b = 1'b0; cool_b = 2; end
        else if (req_b) begin if ($urandom_range(7) == 0) req_b = 1'b0; end
        else if (cool_b > 0) cool_b--;
        else if ($urandom_range(2) == 0) begin
          req_b = 1'b1; addr_b = 3'($urandom_range(7)); data_b = 11'($urandom);
        end
      end
      req_a = 1'b0; req_b = 1'b0;
      tick(); tick(); tick();
      for (int i = 0; i < 8; i++)
        if (written[i]) chk($sformatf("rand_bank%0d", i), 32'(bank[i]), 32'(bank_m[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset; 0 = reset.
REQ-004 req_a  input  1  requester A write request; held high until gnt_a.
REQ-005 addr_a  input  3  requester A target register index (0-7).
REQ-006 data_a  input  11  requester A write data.
REQ-007 req_b, addr_b, data_b  input  1/3/11  requester B, same meaning as A.
REQ-008 gnt_a, gnt_b  output  1 each  one-cycle grant pulse to the winning requester.
REQ-009 chosen  output  8  one-hot register select to the 11-bit register bank; all-zero when idle.
REQ-010 w_en  output  1  bank write enable; high for exactly one cycle per accepted request.
REQ-011 w_data  output  11  bank write data; valid while w_en high, 0 otherwise.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 err  output  1  sticky protocol-error flag.

Function
REQ-014 FSM states: IDLE, GRANT, COMMIT; all outputs SHALL be registered.
REQ-015 IDLE: no request -> stay IDLE; any req high at edge -> GRANT, latch winner's addr/data, set winner id.
REQ-016 GRANT: the winner's gnt SHALL be high for this one cycle only; next state COMMIT unconditionally.
REQ-017 COMMIT: w_en=1, chosen=one-hot(latched addr), w_data=latched data for one cycle; next state IDLE.
REQ-018 Latency: req sampled at edge k -> gnt high in cycle k+1 -> w_en high in cycle k+2 -> IDLE in cycle k+3.
REQ-019 Throughput: at most one write per 3 cycles; new requests are sampled only in IDLE.
REQ-020 Both requests high in IDLE: the winner is set by the arbitration policy (REQ-029/REQ-030); the loser stays pending, no grant.
REQ-021 A request dropped before grant SHALL be withdrawn silently: no grant, no write, no error.
REQ-022 Both requesters targeting the same address SHALL be serialized; the later commit's data is final.
REQ-023 The granted requester SHALL drop req in COMMIT; req still high in COMMIT sets err=1.
REQ-024 err SHALL remain 1 until reset.
REQ-025 chosen SHALL never have more than one bit set; w_en=0 implies chosen=0.

Reset
REQ-026 rst low SHALL asynchronously force: state IDLE, gnt_a=gnt_b=0, chosen=0, w_en=0, w_data=0, busy=0, err=0, last-winner pointer=B, so A wins the first tie.
REQ-027 Reset asserted in GRANT or COMMIT SHALL abort the transaction; no partial write reaches the bank.
REQ-028 After rst rises, the first request SHALL be sampled on the first rising clk edge.

Configuration
REQ-029 With macro ARB_ROUND_ROBIN_EN defined: a tie SHALL be won by the requester that is not the last winner; the pointer updates on every grant.
REQ-030 Without ARB_ROUND_ROBIN_EN: fixed priority; A SHALL always win ties; the pointer logic is absent.

Verification
REQ-031 Reset, then req_a=1, addr_a=3, data_a=11'h5A5 at edge 0 -> gnt_a in cycle 1; w_en=1, chosen=8'h08, w_data=11'h5A5 in cycle 2; busy=0 in cycle 3.
REQ-032 req_a and req_b both high continuously with ARB_ROUND_ROBIN_EN -> grants A, B, A, B, each 3 cycles apart; without the macro -> A only, and B is never granted while A is held.
REQ-033 req_b raised and then dropped before grant while A holds the arbiter -> no gnt_b, no write with B's address, err=0.
REQ-034 Granted requester holds req high into COMMIT -> err=1 from the next cycle, still 1 after 10 idle cycles; rst low clears it.
REQ-035 rst pulsed low during COMMIT of addr 5 -> w_en=0, chosen=0 immediately; bank register 5 is unchanged.
REQ-036 A writes addr 7 = 11'h001, then B writes addr 7 = 11'h7FF -> two w_en pulses 3 cycles apart; final w_data=11'h7FF.
